regs_mp: RTL
============

Name: regs_mp

Overview:
- Parametrised multi-port integer register file; next generation of the core's two-read/two-write register file.
- Adds N read ports, N prioritised write ports and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard for the issue stage, and a post-reset clear sweep that zeroes every register.
- Sits between decode/issue (read and busy-set side) and execute/memory writeback (write side).

Parameters:
- XLEN, 32, data width of each register.
- DEPTH, 32, number of registers; power of two, >= 4; register 0 hardwired to zero.
- AW, 5, address width; must equal log2(DEPTH).
- NREAD, 2, number of read ports.
- NWRITE, 2, number of write ports; index 0 has highest priority.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ready  out  1  high when the file is usable; low during the clear sweep.
- raddr  in  NREAD*AW  read addresses; port i at bits [i*AW +: AW].
- rdata  out  NREAD*XLEN  read data, combinational; port i at [i*XLEN +: XLEN].
- rbusy  out  NREAD  scoreboard busy bit of each read address, combinational.
- we  in  NWRITE  write enables.
- waddr  in  NWRITE*AW  write addresses.
- wdata  in  NWRITE*XLEN  write data.
- set_en  in  1  mark register set_addr busy (instruction issued with rd).
- set_addr  in  AW  register to mark busy.

Behaviour:
- State machine: INIT, RUN.
  - Reset (async) forces INIT, sweep counter = 1, all busy bits = 0, ready = 0.
  - In INIT, each clock zeroes register[counter] and increments the counter.
  - When the counter equals DEPTH-1, that register is zeroed and the state moves to RUN.
  - ready is registered and rises on the same edge the state moves to RUN: DEPTH-1 rising edges after rst deasserts (31 for defaults).
- In INIT:
  - we and set_en are ignored.
  - rdata = 0 and rbusy = 0 on all ports.
- rst asserted mid-sweep or mid-operation: immediate return to INIT; the sweep restarts from 1.
- Writes (RUN):
  - Each enabled port with waddr != 0 writes at the clock edge.
  - Distinct addresses are all written in the same cycle.
  - Same address on several ports: the lowest-index port wins; the others are dropped.
- Register 0: writes are ignored, reads return 0, never busy, set_en to 0 is ignored, and it is never bypassed.
- Reads: rdata[i] = register[raddr[i]]; bypass rules are under Optional Feature.
- Scoreboard (RUN):
  - At each edge, the busy bit of every address written by an enabled port (after priority) is cleared.
  - Then, if set_en is high, busy[set_addr] is set.
  - Set and clear of the same address in the same cycle: set wins (new producer is pending).
- rbusy[i] = busy[raddr[i]] as registered state; it does not reflect this cycle's set or clear.
- Width rules:
  - No arithmetic on data; XLEN bits are stored verbatim.
  - Addresses are used as-is; AW bits cover DEPTH exactly, so there is no out-of-range case.

Optional Feature:
- Macro: REGS_MP_BYPASS_EN.
- Defined:
  - rdata[i] returns wdata of the lowest-index enabled write port whose waddr == raddr[i] and != 0.
  - Otherwise it returns the stored value; no bypass in INIT.
  - rbusy[i] is forced to 0 when a bypassing write matches raddr[i] in that cycle.
- Not defined:
  - rdata reflects stored contents only; a write becomes visible the cycle after its edge.
  - rbusy is pure registered state.

Test Plan:
- Reset then sweep: rst pulse after preloading via hierarchical force -> ready stays 0 for 30 edges, rises on the 31st; every register reads 0 and rbusy = 0 afterwards.
- Dual write, distinct addresses: we = 2'b11, waddr = {5, 3}, wdata = {0xBBBB, 0xAAAA} -> next cycle r3 = 0xAAAA and r5 = 0xBBBB.
- Write conflict: both ports write r7 (0x11 on port 0, 0x22 on port 1) -> r7 = 0x11.
- Register 0: write 0xFFFF to r0 on both ports and set_en on r0 -> rdata = 0 and rbusy = 0, with and without REGS_MP_BYPASS_EN.
- Scoreboard: set_en on r9 -> rbusy 1 next cycle. Then same cycle write r9 by port 1 and set_en r9 -> stays busy. Then write r9 alone -> clears next cycle.
- Bypass and mid-op reset:
  - With REGS_MP_BYPASS_EN: write 0x1234 to r4 while raddr[0] = 4 -> rdata[0] = 0x1234 in the same cycle.
  - Without it: rdata[0] shows 0x1234 one cycle later.
  - Assert rst during sweep count 10 -> ready drops and the sweep restarts, needing 31 edges.

Source files
------------

// File: rtl/regs_mp.sv
// Multi-port integer register file with prioritised writes, busy scoreboard and post-reset clear sweep.
// Optional same-cycle write-to-read bypass when REGS_MP_BYPASS_EN is defined.
module regs_mp #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ready,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*XLEN-1:0]  rdata,
  output logic [NREAD-1:0]       rbusy,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   waddr,
  input  logic [NWRITE*XLEN-1:0] wdata,
  input  logic                   set_en,
  input  logic [AW-1:0]          set_addr
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t              state, state_nx;
  logic [AW-1:0]       counter;
  logic [DEPTH-1:0]    busy;
  logic [XLEN-1:0]     regs [DEPTH];
  logic [AW-1:0]       ra;
  logic                sweep_done;

  assign sweep_done = (state == INIT) && (counter == LAST);

  always_comb begin
    state_nx = state;
    if (sweep_done) state_nx = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      counter <= AW'(1);
      ready   <= 1'b0;
      busy    <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) begin
        counter <= counter + 1'b1;
        if (sweep_done) ready <= 1'b1;
      end else begin
        for (int w = 0; w < NWRITE; w++) begin
          if (we[w]) busy[waddr[w*AW +: AW]] <= 1'b0;
        end
        // Issuing a new producer outranks a retiring one on the same register.
        if (set_en && set_addr != '0) busy[set_addr] <= 1'b1;
      end
    end
  end

  // Storage has no reset; the sweep zeroes it. Descending loop lets port 0 win.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      regs[counter] <= '0;
    end else begin
      for (int w = NWRITE - 1; w >= 0; w--) begin
        if (we[w] && waddr[w*AW +: AW] != '0)
          regs[waddr[w*AW +: AW]] <= wdata[w*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int p = 0; p < NREAD; p++) begin
      ra = raddr[p*AW +: AW];
      if (state == RUN && ra != '0) begin
        rdata[p*XLEN +: XLEN] = regs[ra];
        rbusy[p]              = busy[ra];
`ifdef REGS_MP_BYPASS_EN
        for (int w = NWRITE - 1; w >= 0; w--) begin
          if (we[w] && waddr[w*AW +: AW] == ra) begin
            rdata[p*XLEN +: XLEN] = wdata[w*XLEN +: XLEN];
            rbusy[p]              = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule
